// File: rtl/jtag_cmd_master.sv
// Byte-stream command master: decodes opcode/address/data frames from a JTAG FIFO into bus cycles
// and returns a status byte (plus read data). Bus timeout is built only with JTAG_CMD_MASTER_TIMEOUT_EN.
module jtag_cmd_master #(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_avail,
    output logic              rx_read,
    output logic [7:0]        tx_data,
    output logic              tx_write,
    input  logic              tx_ready,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    output logic              bus_write,
    output logic              bus_read,
    input  logic [31:0]       bus_rdata,
    input  logic              bus_ack
);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP, RDATA} state_t;

    localparam logic [7:0] OP_PING  = 8'h00;
    localparam logic [7:0] OP_WRITE = 8'h01;
    localparam logic [7:0] OP_READ  = 8'h02;
    localparam logic [7:0] RSP_PING = 8'hA0;
    localparam logic [7:0] RSP_WR   = 8'hA1;
    localparam logic [7:0] RSP_RD   = 8'hA2;
    localparam logic [7:0] RSP_ILL  = 8'hEE;
    localparam logic [1:0] ADDR_LAST = 2'(ADDR_W / 8 - 1);

    if ((ADDR_W % 8) != 0 || ADDR_W < 8 || ADDR_W > 32 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_check
        $error("jtag_cmd_master: parameter out of range");
    end

    state_t              state;
    logic [1:0]          cnt;
    logic                is_write;
    logic                gap;
    logic [31:0]         rdata_q;
    logic [ADDR_W+7:0]   addr_shift;

`ifdef JTAG_CMD_MASTER_TIMEOUT_EN
    localparam logic [7:0] RSP_TMO = 8'hEF;
    logic [15:0] tmo_cnt;
    logic [15:0] tmo_next;
    assign tmo_next = tmo_cnt + 16'd1;
`endif

    assign addr_shift = {bus_addr, rx_data};

    // Pops are combinational so the show-ahead head byte is sampled in the same cycle it is popped.
    assign rx_read  = rst_n && rx_avail && (state == IDLE || state == ADDR || state == DATA);
    // gap forces an idle cycle after every push because the FIFO full flag lags by one cycle.
    assign tx_write = tx_ready && !gap && (state == RESP || state == RDATA);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 2'd0;
            is_write  <= 1'b0;
            gap       <= 1'b0;
            rdata_q   <= 32'd0;
            tx_data   <= 8'h00;
            bus_addr  <= '0;
            bus_wdata <= 32'd0;
            bus_write <= 1'b0;
            bus_read  <= 1'b0;
`ifdef JTAG_CMD_MASTER_TIMEOUT_EN
            tmo_cnt   <= 16'd0;
`endif
        end else begin
            gap <= tx_write;
`ifdef JTAG_CMD_MASTER_TIMEOUT_EN
            if (state != BUS)
                tmo_cnt <= 16'd0;
`endif
            case (state)
                IDLE: begin
                    if (rx_read) begin
                        cnt <= 2'd0;
                        case (rx_data)
                            OP_WRITE: begin
                                is_write <= 1'b1;
                                state    <= ADDR;
                            end
                            OP_READ: begin
                                is_write <= 1'b0;
                                state    <= ADDR;
                            end
                            OP_PING: begin
                                tx_data <= RSP_PING;
                                state   <= RESP;
                            end
                            default: begin
                                tx_data <= RSP_ILL;
                                state   <= RESP;
                            end
                        endcase
                    end
                end
                ADDR: begin
                    if (rx_read) begin
                        bus_addr <= addr_shift[ADDR_W-1:0];
                        cnt      <= cnt + 2'd1;
                        if (cnt == ADDR_LAST) begin
                            cnt <= 2'd0;
                            if (is_write) begin
                                state <= DATA;
                            end else begin
                                state    <= BUS;
                                bus_read <= 1'b1;
                            end
                        end
                    end
                end
                DATA: begin
                    if (rx_read) begin
                        bus_wdata <= {bus_wdata[23:0], rx_data};
                        cnt       <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            cnt       <= 2'd0;
                            state     <= BUS;
                            bus_write <= 1'b1;
                        end
                    end
                end
                BUS: begin
                    // An ack in the same cycle the timeout expires completes the transfer normally.
                    if (bus_ack) begin
                        bus_write <= 1'b0;
                        bus_read  <= 1'b0;
                        state     <= RESP;
                        if (bus_read) begin
                            rdata_q <= bus_rdata;
                            tx_data <= RSP_RD;
                        end else begin
                            tx_data <= RSP_WR;
                        end
                    end
`ifdef JTAG_CMD_MASTER_TIMEOUT_EN
                    else if (tmo_next == 16'(TIMEOUT)) begin
                        tmo_cnt   <= tmo_next;
                        bus_write <= 1'b0;
                        bus_read  <= 1'b0;
                        tx_data   <= RSP_TMO;
                        state     <= RESP;
                    end else begin
                        tmo_cnt <= tmo_next;
                    end
`endif
                end
                RESP: begin
                    if (tx_write) begin
                        if (tx_data == RSP_RD) begin
                            tx_data <= rdata_q[31:24];
                            rdata_q <= {rdata_q[23:0], 8'h00};
                            cnt     <= 2'd0;
                            state   <= RDATA;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                RDATA: begin
                    if (tx_write) begin
                        tx_data <= rdata_q[31:24];
                        rdata_q <= {rdata_q[23:0], 8'h00};
                        cnt     <= cnt + 2'd1;
                        if (cnt == 2'd3)
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
